// File: rtl/sl3_link_recovery_ctrl_if.sv
// -----------------------------------------------------------------------------
// sl3_link_recovery_ctrl_if
//   Bundles the PHY status inputs and the sequencer outputs of the SerialLite III
//   link recovery controller.
//
//   Signals:
//     enable      link enable (level)
//     rx_locked   PHY CDR lock, already in the clk domain
//     rx_aligned  lane alignment done, already in the clk domain
//     err_pulse   one-cycle link error strobe
//     phy_rst     PHY reset request
//     grace       high while downstream error counters must be masked
//     link_up     link qualified
//     fail        retry budget exhausted (sticky until IDLE)
//     retry_cnt   retrains since the last stable link
//
//   Modports: master = the side driving enable/status (bench or system),
//             slave  = the controller.
// -----------------------------------------------------------------------------
interface sl3_link_recovery_ctrl_if #(
    parameter int unsigned RETRY_W = 4
);
    logic               enable;
    logic               rx_locked;
    logic               rx_aligned;
    logic               err_pulse;
    logic               phy_rst;
    logic               grace;
    logic               link_up;
    logic               fail;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output enable, rx_locked, rx_aligned, err_pulse,
        input  phy_rst, grace, link_up, fail, retry_cnt
    );

    modport slave (
        input  enable, rx_locked, rx_aligned, err_pulse,
        output phy_rst, grace, link_up, fail, retry_cnt
    );
endinterface

// File: rtl/sl3_link_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// sl3_link_recovery_ctrl
//   Receive-link bring-up / recovery sequencer for SerialLite III. Holds the PHY
//   in reset, opens a grace window in which lock/alignment/errors are masked,
//   qualifies the link and retrains on loss up to MAX_RETRY times before
//   parking in FAILED.
//
//   Ports:
//     clk    single clock, posedge
//     srst   synchronous active-high reset, highest priority
//     link   sl3_link_recovery_ctrl_if.slave (enable, rx_locked, rx_aligned,
//            err_pulse in; phy_rst, grace, link_up, fail, retry_cnt out)
//
//   All outputs are registered and decoded from the current state, so they
//   follow a state change by one cycle.
//
//   Optional: define ERR_THRESH_EN to retrain when ERR_LIMIT err_pulse strobes
//   land inside one grace-length window while the link is up. Without it
//   err_pulse is ignored.
// -----------------------------------------------------------------------------
module sl3_link_recovery_ctrl #(
    parameter int unsigned GRACE_LOG2 = 6,
    parameter int unsigned RST_HOLD   = 8,
    parameter int unsigned MAX_RETRY  = 15,
    parameter int unsigned RETRY_W    = 4,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input logic                      clk,
    input logic                      srst,
    sl3_link_recovery_ctrl_if.slave  link
);

    localparam int unsigned GW    = GRACE_LOG2 + 1;
    localparam int unsigned RST_W = 8;
    localparam int unsigned ERR_W = 4;

    localparam logic [GW-1:0]      GRACE_LAST = GW'((1 << GRACE_LOG2) - 1);
    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_HOLD - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PHY_RST = 3'd1;
    localparam logic [2:0] S_GRACE   = 3'd2;
    localparam logic [2:0] S_LINK_UP = 3'd3;
    localparam logic [2:0] S_RETRY   = 3'd4;
    localparam logic [2:0] S_FAILED  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [GW-1:0]      grace_cnt_q, grace_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               phy_rst_q, phy_rst_d;
    logic               grace_q, grace_d;
    logic               link_up_q, link_up_d;
    logic               fail_q, fail_d;

    logic               link_ok_c;
    logic               grace_hit_c;
    logic               grace_exp_c;
    logic [GW-1:0]      grace_inc_c;
    logic               err_trip_c;

    assign link_ok_c   = link.rx_locked & link.rx_aligned;
    // hit marks the cycle the counter is about to set its MSB
    assign grace_hit_c = (grace_cnt_q == GRACE_LAST);
    assign grace_exp_c = grace_hit_c | grace_cnt_q[GW-1];
    assign grace_inc_c = grace_cnt_q[GW-1] ? grace_cnt_q : grace_cnt_q + GW'(1);

`ifdef ERR_THRESH_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] err_inc_c;

    // saturating per-window error count; trip on the pulse that reaches the limit
    assign err_inc_c  = (link.err_pulse && (err_cnt_q != {ERR_W{1'b1}}))
                        ? err_cnt_q + ERR_W'(1) : err_cnt_q;
    assign err_trip_c = link.err_pulse && (err_inc_c >= ERR_W'(ERR_LIMIT));

    always_ff @(posedge clk) begin
        if (srst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`else
    logic unused_err_c;

    assign err_trip_c   = 1'b0;
    assign unused_err_c = ^{link.err_pulse, 32'(ERR_LIMIT)};
`endif

    // state, timers and output registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            grace_cnt_q <= '0;
            retry_q     <= '0;
            phy_rst_q   <= 1'b1;
            grace_q     <= 1'b1;
            link_up_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            grace_cnt_q <= grace_cnt_d;
            retry_q     <= retry_d;
            phy_rst_q   <= phy_rst_d;
            grace_q     <= grace_d;
            link_up_q   <= link_up_d;
            fail_q      <= fail_d;
        end
    end

    // next state, timers and output decode
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        grace_cnt_d = grace_cnt_q;
        retry_d     = retry_q;
        phy_rst_d   = 1'b1;
        grace_d     = 1'b1;
        link_up_d   = 1'b0;
        fail_d      = 1'b0;
`ifdef ERR_THRESH_EN
        err_cnt_d   = err_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                if (link.enable) begin
                    state_d = S_PHY_RST;
                end
            end
            S_PHY_RST: begin
                rst_cnt_d = rst_cnt_q + RST_W'(1);
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_GRACE;
                end
            end
            S_GRACE: begin
                phy_rst_d   = 1'b0;
                grace_cnt_d = grace_inc_c;
                if (grace_exp_c) begin
                    state_d = link_ok_c ? S_LINK_UP : S_RETRY;
                end
            end
            S_LINK_UP: begin
                phy_rst_d   = 1'b0;
                grace_d     = 1'b0;
                link_up_d   = 1'b1;
                grace_cnt_d = grace_inc_c;
`ifdef ERR_THRESH_EN
                err_cnt_d   = err_inc_c;
`endif
                if (!link_ok_c || err_trip_c) begin
                    // loss beats a coincident window expiry: retry_cnt kept
                    state_d = S_RETRY;
                end else if (grace_hit_c) begin
                    // retry_cnt cannot rise while here, so clearing at every
                    // boundary equals clearing at the first one
                    retry_d = '0;
`ifdef ERR_THRESH_EN
                    grace_cnt_d = '0;
                    err_cnt_d   = '0;
`endif
                end
            end
            S_RETRY: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = S_FAILED;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_PHY_RST;
                end
            end
            S_FAILED: begin
                fail_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // disable overrides any transition, including a pending retry
        if (!link.enable) begin
            state_d = S_IDLE;
            if (state_q == S_RETRY) begin
                retry_d = retry_q;
            end
        end

        // entry clears
        if (state_d != state_q) begin
            if (state_d == S_PHY_RST) begin
                rst_cnt_d = '0;
            end
            if ((state_d == S_GRACE) || (state_d == S_LINK_UP)) begin
                grace_cnt_d = '0;
            end
`ifdef ERR_THRESH_EN
            err_cnt_d = '0;
`endif
        end
    end

    assign link.phy_rst   = phy_rst_q;
    assign link.grace     = grace_q;
    assign link.link_up   = link_up_q;
    assign link.fail      = fail_q;
    assign link.retry_cnt = retry_q;

endmodule

// File: tb/tb_sl3_link_recovery_ctrl.sv
module tb_sl3_link_recovery_ctrl;

    typedef struct packed {
        logic       phy_rst;
        logic       grace;
        logic       link_up;
        logic       fail;
        logic [3:0] retry;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t o;
    } sb_t;

    logic clk;
    logic srst;
    int   n_vec;
    int   n_miss;
    sb_t  sb_q[$];

    sl3_link_recovery_ctrl_if #(.RETRY_W(4)) bus ();

    sl3_link_recovery_ctrl #(
        .GRACE_LOG2 (6),
        .RST_HOLD   (8),
        .MAX_RETRY  (3),
        .RETRY_W    (4),
        .ERR_LIMIT  (4)
    ) dut (
        .clk  (clk),
        .srst (srst),
        .link (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk(input logic p, input logic g, input logic l,
                                 input logic f, input logic [3:0] r);
        outs_t o;
        o.phy_rst = p;
        o.grace   = g;
        o.link_up = l;
        o.fail    = f;
        o.retry   = r;
        return o;
    endfunction

    function automatic outs_t sample();
        return mk(bus.phy_rst, bus.grace, bus.link_up, bus.fail, bus.retry_cnt);
    endfunction

    // synchronous reset; the next edge after this is cycle 1 of a scenario
    task automatic reset_dut();
        srst           = 1'b1;
        bus.enable     = 1'b0;
        bus.rx_locked  = 1'b0;
        bus.rx_aligned = 1'b0;
        bus.err_pulse  = 1'b0;
        @(posedge clk); #1;
        srst = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        outs_t obs;
        srst       = 1'b1;
        bus.enable = 1'b1;
        bus.rx_locked = 1'b1;
        bus.rx_aligned = 1'b1;
        bus.err_pulse = 1'b0;
        sb_q.push_back('{cyc: 1, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 2, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL reset cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
        end
        srst = 1'b0;
    endtask

    // clean bring-up: phy_rst 8 cycles, 64-cycle grace, link up after
    task automatic test_bringup();
        sb_t e;
        outs_t obs;
        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b1;
        bus.rx_aligned = 1'b1;
        for (int k = 1; k <= 80; k++)
            sb_q.push_back('{cyc: k, o: mk(k < 10, k < 74, k >= 74, 1'b0, 4'd0)});
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL bringup cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
        end
    endtask

    // alignment chatter inside the window is masked
    task automatic test_grace_mask();
        sb_t e;
        outs_t obs;
        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b1;
        bus.rx_aligned = 1'b1;
        for (int k = 1; k <= 80; k++)
            sb_q.push_back('{cyc: k, o: mk(k < 10, k < 74, k >= 74, 1'b0, 4'd0)});
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL grace_mask cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
            bus.rx_aligned = (k >= 9 && k < 68) ? k[0] : 1'b1;
        end
    endtask

    // lock never comes: three retrains then sticky fail; disable recovers
    task automatic test_exhaust();
        sb_t e;
        outs_t obs;
        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b0;
        bus.rx_aligned = 1'b1;
        sb_q.push_back('{cyc: 73,  o: mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 74,  o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1)});
        sb_q.push_back('{cyc: 75,  o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1)});
        sb_q.push_back('{cyc: 147, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd2)});
        sb_q.push_back('{cyc: 220, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd3)});
        sb_q.push_back('{cyc: 293, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd3)});
        sb_q.push_back('{cyc: 294, o: mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd3)});
        sb_q.push_back('{cyc: 400, o: mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd3)});
        sb_q.push_back('{cyc: 402, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 403, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        for (int k = 1; k <= 403; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL exhaust cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
            if (k == 400) bus.enable = 1'b0;
        end
    endtask

    // retry_cnt=2 at link up, loss -> 3, one stable window -> 0
    task automatic test_retry_clear();
        sb_t e;
        outs_t obs;
        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b0;
        bus.rx_aligned = 1'b1;
        sb_q.push_back('{cyc: 147, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd2)});
        sb_q.push_back('{cyc: 220, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd2)});
        sb_q.push_back('{cyc: 229, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd2)});
        sb_q.push_back('{cyc: 230, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd3)});
        sb_q.push_back('{cyc: 303, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd3)});
        sb_q.push_back('{cyc: 365, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd3)});
        sb_q.push_back('{cyc: 366, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
        for (int k = 1; k <= 370; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL retry_clear cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
            if (k == 150) bus.rx_locked = 1'b1;
            if (k == 228) bus.rx_locked = 1'b0;
            if (k == 229) bus.rx_locked = 1'b1;
        end
    endtask

    // srst mid-grace, then disable coincident with lock loss
    task automatic test_abort();
        sb_t e;
        outs_t obs;
        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b1;
        bus.rx_aligned = 1'b1;
        sb_q.push_back('{cyc: 30, o: mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 31, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 32, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL srst_grace cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
            srst = (k == 30);
        end

        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b0;
        bus.rx_aligned = 1'b1;
        sb_q.push_back('{cyc: 147, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd1)});
        sb_q.push_back('{cyc: 161, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd1)});
        sb_q.push_back('{cyc: 162, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 170, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0)});
        for (int k = 1; k <= 170; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL disable_loss cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
            if (k == 80) bus.rx_locked = 1'b1;
            if (k == 160) begin
                bus.rx_locked = 1'b0;
                bus.enable    = 1'b0;
            end
        end
    endtask

    // error pulses while the link is up (link_up state entered at cycle 73)
    task automatic test_err_pulse();
        sb_t e;
        outs_t obs;
        logic pulse;
        reset_dut();
        bus.enable = 1'b1;
        bus.rx_locked = 1'b1;
        bus.rx_aligned = 1'b1;
`ifdef ERR_THRESH_EN
        sb_q.push_back('{cyc: 137, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 200, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 226, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 227, o: mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1)});
`else
        sb_q.push_back('{cyc: 100, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 120, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
        sb_q.push_back('{cyc: 227, o: mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)});
`endif
        for (int k = 1; k <= 230; k++) begin
            @(posedge clk); #1;
            obs = sample();
            while (sb_q.size() != 0 && sb_q[0].cyc == k) begin
                e = sb_q.pop_front();
                n_vec++;
                if (obs !== e.o) begin
                    n_miss++;
                    $display("FAIL err_pulse cyc=%0d got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", k,
                             obs.phy_rst, obs.grace, obs.link_up, obs.fail, obs.retry,
                             e.o.phy_rst, e.o.grace, e.o.link_up, e.o.fail, e.o.retry);
                end
            end
`ifdef ERR_THRESH_EN
            // 3 per window in the first two windows, 4 in the third
            pulse = (k == 80 || k == 90 || k == 100 ||
                     k == 140 || k == 150 || k == 160 ||
                     k == 210 || k == 215 || k == 220 || k == 225);
`else
            // 20 pulses, none of which may disturb the link
            pulse = (k >= 80 && k < 120 && k[0] == 1'b0);
`endif
            bus.err_pulse = pulse;
        end
        bus.err_pulse = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        srst   = 1'b1;
        bus.enable     = 1'b0;
        bus.rx_locked  = 1'b0;
        bus.rx_aligned = 1'b0;
        bus.err_pulse  = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_bringup();
        test_grace_mask();
        test_exhaust();
        test_retry_clear();
        test_abort();
        test_err_pulse();

        n_vec++;
        if (sb_q.size() !== 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
